alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer for the shared 8-bit signed ALU. It accepts operation requests (opcode, two operands) from two independent requesters over valid/ready handshakes and grants the ALU round-robin. It executes one operation at a time through the combinational ALU core and returns the registered 8-bit result to the originating requester over a valid/ready response channel. It sits between the requesters and the ALU datapath, and is the only path into the ALU.

## Interface
- `CNT_W`, default 16: width of the grant counters. Used only when `ALU_ARB_CNT_EN` is defined.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted on this edge when valid is also high.
- `req0_sel` / `req1_sel`  in  3  ALU opcode.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  8  signed operands.
- `rsp0_valid` / `rsp1_valid`  out  1  result available.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the result.
- `rsp0_data` / `rsp1_data`  out  8  result byte.
- `gnt0_cnt` / `gnt1_cnt`  out  `CNT_W`  accepted-request counters. Present only with `ALU_ARB_CNT_EN`.

## Operation
- The FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant logic is combinational.
  - If only one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester other than `last_gnt` is granted.
  - `reqN_ready` = (state == IDLE) && (grant == N) && !rst.
  - On a handshake:
    - latch sel, a and b into the operand registers;
    - latch the owner id;
    - set `last_gnt` to the owner;
    - go to EXEC.
- **EXEC**
  - The ALU core evaluates the latched operands.
  - Its output is registered into `result`.
  - Go to RESP.
- **RESP**
  - `rspN_valid` is high for the owner only, and `rspN_data` = `result`.
  - When `rspN_ready` is high, go to IDLE.
  - Otherwise hold: data stable, valid stays high.
- `rsp_data` of the non-owner port = `result` (don't-care; the bench checks data only when valid is high).
- All arithmetic is signed. The result byte per opcode:
  - 0: 9-bit (a+b), bits [8:1].
  - 1: 9-bit (a−b), bits [8:1].
  - 2: a AND b.
  - 3: a OR b.
  - 4: a XOR b.
  - 5: 11-bit (signed 7-bit a[7:1] + signed 10-bit {b,2'b00}), bits [10:3].
  - 6: 11-bit 3·(a+b), using the 9-bit sum, bits [10:3].
  - 7: 16-bit a·b, bits [15:8].
- Reset values:
  - state = IDLE, `last_gnt` = 1 (requester 0 wins first), `result` = 0, owner = 0.
  - All `rsp*_valid` = 0, all `req*_ready` = 0.
  - Counters = 0.
- Reset in any state aborts the operation immediately. The in-flight result is discarded and no response is issued.

## Timing
- Request accepted at edge k → result registered at edge k+1 → `rspN_valid` high in the cycle after edge k+1 (2-cycle latency).
- Response taken at edge m → IDLE from m. Next accept at edge m+1 at the earliest.
- Peak throughput is one operation per 3 cycles.
- `reqN_ready` depends combinationally on `reqN_valid` and state. Requesters must not make valid depend on ready.
- Requests pending during EXEC/RESP see ready = 0. They must hold valid and payload stable.
- Valid and ready both high on the response port with reset deasserting in the same cycle: reset dominates.

## Configuration
- **`ALU_ARB_CNT_EN` defined:**
  - adds `gnt0_cnt` and `gnt1_cnt`;
  - each counter increments by 1 on every accepted request of its port;
  - each counter wraps from all-ones to 0;
  - both reset to 0.
- **`ALU_ARB_CNT_EN` undefined:** the ports and counter logic are absent. Behaviour is otherwise identical.

## Structure
- Package `alu_arb_pkg` holds:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_MATH1=5, OP_MATH2=6, OP_MUL=7;
  - the FSM state typedef (IDLE/EXEC/RESP);
  - DATA_W=8.
- Sub-module `alu8_core` is purely combinational: (sel, a, b) → 8-bit result per the opcode table. The arbiter instantiates it once.

## Test plan
- req0 sel=0, a=100, b=50 → `rsp0_data`=8'h4B, with `rsp0_valid` 2 cycles after accept.
- req1 sel=1, a=8'h80, b=1 → 8'hBF. sel=7, a=64, b=4 → 8'h01. sel=7, a=−2, b=3 → 8'hFF.
- req0 sel=5, a=8'h10, b=8'h01 → 8'h01. sel=6, a=10, b=6 → 8'h06.
- Both requesters valid continuously from reset → grants alternate 0,1,0,1. Each response goes only to its owner. Counters (with `ALU_ARB_CNT_EN`) equal after an even number of grants.
- `rsp0_ready` held low 5 cycles in RESP → `rsp0_valid` and data stable, both `req*_ready` = 0. Release → IDLE, next accept on the following edge.
- `rst` pulsed during RESP → `rsp*_valid` drops without waiting for a clock edge, and no response is issued. After release with both valid, requester 0 is granted first.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared definitions for the two-port ALU arbiter: datapath width, ALU
// opcode encodings and the sequencer state type.
// No ports (package).
package alu_arb_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_MATH1 = 3'd5;
    localparam logic [2:0] OP_MATH2 = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Request/response bundle between the two requesters and the arbiter.
//   reqN_valid/ready, reqN_sel, reqN_a, reqN_b : request channel, port N
//   rspN_valid/ready, rspN_data                : response channel, port N
//   gntN_cnt                                   : accepted-request counters
//                                                (only with ALU_ARB_CNT_EN)
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int CNT_W = 16
);
    import alu_arb_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [2:0]        req0_sel;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req1_valid;
    logic              req1_ready;
    logic [2:0]        req1_sel;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;

`ifdef ALU_ARB_CNT_EN
    logic [CNT_W-1:0]  gnt0_cnt;
    logic [CNT_W-1:0]  gnt1_cnt;

    modport master (
        output req0_valid, req0_sel, req0_a, req0_b,
        output req1_valid, req1_sel, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  gnt0_cnt, gnt1_cnt
    );

    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b,
        input  req1_valid, req1_sel, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output gnt0_cnt, gnt1_cnt
    );
`else
    modport master (
        output req0_valid, req0_sel, req0_a, req0_b,
        output req1_valid, req1_sel, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b,
        input  req1_valid, req1_sel, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
`endif

endinterface

// File: rtl/alu8_core.sv
// alu8_core
// Purely combinational 8-bit signed ALU.
//   i_sel : opcode (see alu_arb_pkg)
//   i_a   : signed operand a
//   i_b   : signed operand b
//   o_y   : result byte
module alu8_core
    import alu_arb_pkg::*;
(
    input  logic        [2:0]        i_sel,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic        [DATA_W-1:0] o_y
);

    logic signed [8:0]  w_sum;
    logic signed [8:0]  w_diff;
    logic signed [10:0] w_math1;
    logic signed [10:0] w_sum11;
    logic signed [10:0] w_math2;
    logic signed [15:0] w_a16;
    logic signed [15:0] w_b16;
    logic signed [15:0] w_mul;

    // Widen with sign extension before each operation so no carry is lost.
    assign w_sum   = {i_a[7], i_a} + {i_b[7], i_b};
    assign w_diff  = {i_a[7], i_a} - {i_b[7], i_b};
    // Signed 7-bit a[7:1] plus signed 10-bit b*4, both extended to 11 bits.
    assign w_math1 = {{4{i_a[7]}}, i_a[7:1]} + {i_b[7], i_b, 2'b00};
    // 3*(a+b) as sum + 2*sum.
    assign w_sum11 = {{2{w_sum[8]}}, w_sum};
    assign w_math2 = w_sum11 + {w_sum11[9:0], 1'b0};
    assign w_a16   = {{8{i_a[7]}}, i_a};
    assign w_b16   = {{8{i_b[7]}}, i_b};
    assign w_mul   = w_a16 * w_b16;

    // Arithmetic shift then truncate selects the upper byte of each result.
    always_comb begin
        o_y = '0;
        case (i_sel)
            OP_ADD:   o_y = 8'(w_sum >>> 1);
            OP_SUB:   o_y = 8'(w_diff >>> 1);
            OP_AND:   o_y = i_a & i_b;
            OP_OR:    o_y = i_a | i_b;
            OP_XOR:   o_y = i_a ^ i_b;
            OP_MATH1: o_y = 8'(w_math1 >>> 3);
            OP_MATH2: o_y = 8'(w_math2 >>> 3);
            OP_MUL:   o_y = 8'(w_mul >>> 8);
            default:  o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter and sequencer for the shared 8-bit signed ALU.
// One operation at a time: IDLE (accept) -> EXEC (register result) ->
// RESP (hold result until the owner takes it).
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : alu_arbiter_if slave (request + response channels, both ports)
// Optional macro ALU_ARB_CNT_EN adds per-port accepted-request counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_owner;
    logic              r_last_gnt;
    logic [2:0]        r_sel;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_grant;
    logic              w_accept;
    logic              w_rsp_take;

    // Round-robin: a lone requester wins; on contention the port that did
    // not win last time goes first.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_gnt;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign bus.req0_ready = (r_state == IDLE) && !w_grant && !rst;
    assign bus.req1_ready = (r_state == IDLE) &&  w_grant && !rst;
    assign w_accept = (bus.req0_valid && bus.req0_ready) ||
                      (bus.req1_valid && bus.req1_ready);
    assign w_rsp_take = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (w_rsp_take) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_sel      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
        end else begin
            if (w_accept) begin
                r_owner    <= w_grant;
                r_last_gnt <= w_grant;
                r_sel      <= w_grant ? bus.req1_sel : bus.req0_sel;
                r_a        <= w_grant ? bus.req1_a   : bus.req0_a;
                r_b        <= w_grant ? bus.req1_b   : bus.req0_b;
            end
            if (r_state == EXEC) begin
                r_result <= w_alu_y;
            end
        end
    end

    alu8_core u_alu (
        .i_sel (r_sel),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_y   (w_alu_y)
    );

    // Valid derives from the state register, so reset drops it at once.
    assign bus.rsp0_valid = (r_state == RESP) && !r_owner;
    assign bus.rsp1_valid = (r_state == RESP) &&  r_owner;
    assign bus.rsp0_data  = r_result;
    assign bus.rsp1_data  = r_result;

`ifdef ALU_ARB_CNT_EN
    logic [CNT_W-1:0] r_gnt0_cnt;
    logic [CNT_W-1:0] r_gnt1_cnt;

    // Counters wrap naturally from all-ones to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else if (w_accept) begin
            if (w_grant) r_gnt1_cnt <= r_gnt1_cnt + CNT_W'(1);
            else         r_gnt0_cnt <= r_gnt0_cnt + CNT_W'(1);
        end
    end

    assign bus.gnt0_cnt = r_gnt0_cnt;
    assign bus.gnt1_cnt = r_gnt1_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// hold / alternation / reset sequences, then randomized traffic compared
// against an integer-arithmetic reference model.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_arbiter_if #(.CNT_W(16)) bus ();

    alu_arbiter #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Requester-side state: pending flag and held payload per port.
    logic       pend  [2];
    logic [2:0] p_sel [2];
    logic [7:0] p_a   [2];
    logic [7:0] p_b   [2];

    // Reference arbitration state and grant counts.
    logic m_last;
    int   m_cnt [2];

    typedef struct {
        logic       port;
        logic [2:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        int         hold;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result byte from the opcode rules using plain integer arithmetic.
    function automatic logic [7:0] ref_alu(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (sel)
            3'd0:    r = (sa + sb) >>> 1;
            3'd1:    r = (sa - sb) >>> 1;
            3'd2:    r = int'(a & b);
            3'd3:    r = int'(a | b);
            3'd4:    r = int'(a ^ b);
            3'd5:    r = ((sa >>> 1) + sb * 4) >>> 3;
            3'd6:    r = (3 * (sa + sb)) >>> 3;
            default: r = (sa * sb) >>> 8;
        endcase
        return r[7:0];
    endfunction

    function automatic logic model_grant();
        if (pend[0] && pend[1]) return ~m_last;
        return pend[1] && !pend[0];
    endfunction

    function automatic logic req_ready(input logic p);
        return p ? bus.req1_ready : bus.req0_ready;
    endfunction

    function automatic logic rsp_valid(input logic p);
        return p ? bus.rsp1_valid : bus.rsp0_valid;
    endfunction

    function automatic logic [7:0] rsp_data(input logic p);
        return p ? bus.rsp1_data : bus.rsp0_data;
    endfunction

    task automatic apply();
        bus.req0_valid = pend[0];
        bus.req0_sel   = p_sel[0];
        bus.req0_a     = p_a[0];
        bus.req0_b     = p_b[0];
        bus.req1_valid = pend[1];
        bus.req1_sel   = p_sel[1];
        bus.req1_a     = p_a[1];
        bus.req1_b     = p_b[1];
    endtask

    task automatic set_req(input logic p, input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        pend[p]  = 1'b1;
        p_sel[p] = sel;
        p_a[p]   = a;
        p_b[p]   = b;
    endtask

    // One full transaction from IDLE; called just after a falling edge.
    // gd reports which port the DUT actually granted.
    task automatic run_op(input logic [7:0] exp, input int hold, output logic gd);
        logic g;
        g = model_grant();
        apply();
        #1;
        gd = bus.req1_ready && !bus.req0_ready;
        check("idle_rsp0_valid", 32'(bus.rsp0_valid), 0);
        check("idle_rsp1_valid", 32'(bus.rsp1_valid), 0);
        check("grant_ready", 32'(req_ready(g)), 1);
        check("loser_ready", 32'(req_ready(~g)), 0);
        @(negedge clk);
        pend[g] = 1'b0;
        m_last  = g;
        m_cnt[g]++;
        apply();
        #1;
        check("exec_ready0", 32'(bus.req0_ready), 0);
        check("exec_ready1", 32'(bus.req1_ready), 0);
        check("exec_rsp_valid", 32'(bus.rsp0_valid | bus.rsp1_valid), 0);
        @(negedge clk);
        #1;
        check("rsp_valid_owner", 32'(rsp_valid(g)), 1);
        check("rsp_valid_other", 32'(rsp_valid(~g)), 0);
        check("rsp_data", 32'(rsp_data(g)), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid(g)), 1);
            check("hold_data", 32'(rsp_data(g)), 32'(exp));
            check("hold_ready", 32'(bus.req0_ready | bus.req1_ready), 0);
        end
        if (g) bus.rsp1_ready = 1'b1;
        else   bus.rsp0_ready = 1'b1;
        @(negedge clk);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic check_counters(input string name);
`ifdef ALU_ARB_CNT_EN
        check({name, "_cnt0"}, 32'(bus.gnt0_cnt), 32'(m_cnt[0]));
        check({name, "_cnt1"}, 32'(bus.gnt1_cnt), 32'(m_cnt[1]));
`else
        n_checks = n_checks + 0;
`endif
    endtask

    task automatic reset_model();
        m_last   = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    initial begin
        logic       gd;
        logic [7:0] exp;

        vecs[0]  = '{1'b0, 3'd0, 8'd100, 8'd50,  8'h4B, 0};
        vecs[1]  = '{1'b1, 3'd1, 8'h80,  8'h01,  8'hBF, 0};
        vecs[2]  = '{1'b1, 3'd7, 8'd64,  8'd4,   8'h01, 0};
        vecs[3]  = '{1'b1, 3'd7, 8'hFE,  8'h03,  8'hFF, 1};
        vecs[4]  = '{1'b0, 3'd5, 8'h10,  8'h01,  8'h01, 0};
        vecs[5]  = '{1'b0, 3'd6, 8'd10,  8'd6,   8'h06, 0};
        vecs[6]  = '{1'b0, 3'd2, 8'hF0,  8'h3C,  8'h30, 0};
        vecs[7]  = '{1'b1, 3'd3, 8'h0F,  8'h30,  8'h3F, 0};
        vecs[8]  = '{1'b0, 3'd4, 8'hFF,  8'h0F,  8'hF0, 2};
        vecs[9]  = '{1'b1, 3'd0, 8'h7F,  8'h7F,  8'h7F, 0};
        vecs[10] = '{1'b0, 3'd0, 8'h80,  8'h80,  8'h80, 0};
        vecs[11] = '{1'b1, 3'd7, 8'h80,  8'h80,  8'h40, 0};

        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; p_sel[p] = '0; p_a[p] = '0; p_b[p] = '0;
        end
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        rst = 1'b1;
        reset_model();
        apply();

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready0", 32'(bus.req0_ready), 0);
        check("rst_ready1", 32'(bus.req1_ready), 0);
        check("rst_rsp0_valid", 32'(bus.rsp0_valid), 0);
        check("rst_rsp1_valid", 32'(bus.rsp1_valid), 0);
        check("rst_result", 32'(bus.rsp0_data), 0);
        check_counters("rst");
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            set_req(vecs[i].port, vecs[i].sel, vecs[i].a, vecs[i].b);
            run_op(vecs[i].exp, vecs[i].hold, gd);
            check("tbl_grant", 32'(gd), 32'(vecs[i].port));
        end
        check_counters("tbl");

        // Long hold in RESP with the other port waiting, then the waiting
        // request must be accepted on the very next edge.
        set_req(1'b0, 3'd0, 8'd1, 8'd1);
        set_req(1'b1, 3'd2, 8'hAA, 8'h0F);
        run_op(8'h01, 5, gd);
        check("hold_grant", 32'(gd), 0);
        run_op(8'h0A, 0, gd);
        check("after_hold_grant", 32'(gd), 1);

        // Both valid continuously from reset: grants alternate 0,1,0,1.
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        set_req(1'b0, 3'($urandom), 8'($urandom), 8'($urandom));
        set_req(1'b1, 3'($urandom), 8'($urandom), 8'($urandom));
        apply();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g   = model_grant();
            exp = ref_alu(p_sel[g], p_a[g], p_b[g]);
            run_op(exp, 0, gd);
            check("alt_grant", 32'(gd), 32'(i % 2));
            set_req(gd, 3'($urandom), 8'($urandom), 8'($urandom));
        end
        check_counters("alt");

        // Reset while in RESP: valid drops immediately, no response issued,
        // requester 0 wins first afterwards.
        pend[1] = 1'b0;
        set_req(1'b0, 3'd0, 8'd20, 8'd30);
        apply();
        @(negedge clk);
        pend[0] = 1'b0;
        apply();
        @(negedge clk);
        #1;
        check("pre_rst_valid", 32'(bus.rsp0_valid), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rsp0_drop", 32'(bus.rsp0_valid), 0);
        check("async_rsp1_drop", 32'(bus.rsp1_valid), 0);
        reset_model();
        set_req(1'b0, 3'd1, 8'd9, 8'd3);
        set_req(1'b1, 3'd4, 8'h55, 8'hFF);
        apply();
        #1;
        check("rst_gated_ready", 32'(bus.req0_ready | bus.req1_ready), 0);
        @(negedge clk);
        #1;
        check("rst_no_rsp", 32'(bus.rsp0_valid | bus.rsp1_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(ref_alu(3'd1, 8'd9, 8'd3), 0, gd);
        check("post_rst_grant", 32'(gd), 0);
        run_op(ref_alu(3'd4, 8'h55, 8'hFF), 0, gd);
        check("post_rst_grant2", 32'(gd), 1);
        check_counters("post_rst");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic g;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    set_req(1'(p), 3'($urandom), 8'($urandom), 8'($urandom));
            end
            if (!pend[0] && !pend[1])
                set_req(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom));
            g   = model_grant();
            exp = ref_alu(p_sel[g], p_a[g], p_b[g]);
            run_op(exp, int'($urandom_range(0, 2)), gd);
            check("rand_grant", 32'(gd), 32'(g));
        end
        check_counters("rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
